mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register of the pipelined MIPS datapath. Consumes the EX/MEM latch outputs, issues data-cache load/store requests with a dhit handshake, stalls the pipeline while a request is outstanding, and latches the write-back selection and data for the register file. It also owns the sticky processor halt.

## Interface
- Parameters: none. Widths are fixed by cpu_types_pkg: word_t is 32 bits, regbits_t is 5 bits.
- CLK  in  1  pipeline clock; all state updates on the rising edge.
- nRST  in  1  asynchronous, active-low reset.
- pcplus4, aluOutport, rdat2  in  32 each  from the EX/MEM latch outputs.
- rt, rd  in  5 each  from the EX/MEM latch.
- MemToReg, JType, RegDst, regWEN, Halt, dMemREN, dMemWEN  in  1 each  EX/MEM control bits.
- flush  in  1  hazard unit; squashes the instruction currently in MEM.
- dhit  in  1  dcache; request completes this cycle.
- dmemload  in  32  dcache; load data, valid when dhit=1.
- dmemREN, dmemWEN  out  1 each  dcache request strobes.
- dmemaddr  out  32  equals aluOutport.
- dmemstore  out  32  equals rdat2.
- mem_stall  out  1  to the hazard unit; freezes PC, IF/ID, ID/EX and EX/MEM.
- wsel  out  5  registered write-back register index.
- wdat  out  32  registered write-back data.
- wen  out  1  registered register-file write enable.
- halt  out  1  registered sticky halt.

## Operation
- **Request qualification**
  - memop = (dMemREN | dMemWEN) & ~halt & ~flush.
  - dmemWEN = memop & dMemWEN.
  - dmemREN = memop & dMemREN & ~dMemWEN. If both strobes are set, the write wins.
- **FSM states:** RUN, WAIT.
  - RUN, memop=0: the instruction passes through in 1 cycle; mem_stall=0.
  - RUN, memop=1, dhit=1: the access completes and the MEM/WB register loads at this edge; stay in RUN.
  - RUN, memop=1, dhit=0: mem_stall=1; go to WAIT.
  - WAIT: keep the request asserted and mem_stall=1. The MEM/WB register loads a bubble each cycle (wen=0).
  - WAIT, dhit=1: mem_stall=0; the MEM/WB register captures the instruction; go to RUN.
  - mem_stall = memop & ~dhit, identical in both states.
- **MEM/WB capture** (when not stalled and not flushed):
  - wsel = JType ? 5'd31 : (RegDst ? rd : rt).
  - wdat = JType ? pcplus4 : (MemToReg ? dmemload : aluOutport).
  - wen = regWEN & (wsel != 0).
- **Flush** (at an edge with flush=1):
  - MEM/WB loads a bubble (wen=0, wsel=0, wdat=0).
  - The request is dropped and the FSM goes to RUN.
  - halt is not set by the flushed instruction.
  - A store flushed before dhit never reaches the cache.
- **Halt:** when a Halt instruction is captured, halt=1 and stays 1 until nRST.
  - While halt=1: wen is forced to 0, no dcache requests are issued, and mem_stall=0.

## Timing
- **Reset (nRST low):** wen=0, wsel=0, wdat=0, halt=0, FSM=RUN. dmemREN, dmemWEN and mem_stall are forced to 0 while nRST is low. Reset mid-WAIT abandons the request.
- **Latency:**
  - Non-memory instruction: valid on wsel/wdat/wen 1 cycle after it is presented.
  - Memory instruction: captured at the edge where dhit=1. A hit in the first cycle costs 0 stall cycles; N miss cycles cost N stall cycles.
- **Handshake:**
  - dmemaddr, dmemstore and the strobes stay stable from request until dhit, because EX/MEM is frozen by mem_stall.
  - dhit is ignored when no request is active.
- **Simultaneous events:**
  - flush and dhit in the same cycle: flush wins, and the load result is discarded.
  - Halt and a memory op in the same instruction: the memory op is performed, then halt is set.

## Test plan
- ALU op: aluOutport=0x1234, rd=5, RegDst=1, regWEN=1, no memop → the next edge gives wsel=5, wdat=0x1234, wen=1; mem_stall is never 1.
- Load miss: dMemREN=1, MemToReg=1, rt=8, aluOutport=0x100, dhit low for 3 cycles then dmemload=0xDEADBEEF with dhit=1 → dmemREN=1 and mem_stall=1 for 3 cycles, dmemaddr=0x100, then wsel=8, wdat=0xDEADBEEF, wen=1.
- Store hit plus both-strobe case: dMemWEN=1, dMemREN=1, rdat2=0xCAFE, dhit=1 → dmemWEN=1, dmemREN=0, dmemstore=0xCAFE, mem_stall=0.
- Flush in WAIT: load outstanding, flush=1 with dhit=1 in the same cycle → wen=0 at the next edge, FSM=RUN, strobes drop.
- JAL with rt/rd irrelevant: JType=1, regWEN=1, pcplus4=0x44 → wsel=31, wdat=0x44. A write to $0 with rd=0 gives wen=0.
- Halt, then reset mid-WAIT:
  - Halt captured → halt=1; subsequent loads issue no dmemREN and wen stays 0.
  - A separate run: assert nRST low during WAIT → outputs go to 0 immediately and FSM=RUN.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM stage of the pipelined MIPS datapath: qualifies dcache requests, stalls on misses,
// and holds the MEM/WB write-back register and the sticky halt.
module mem_wb_stage (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] pcplus4,
    input  logic [31:0] aluOutport,
    input  logic [31:0] rdat2,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic        MemToReg,
    input  logic        JType,
    input  logic        RegDst,
    input  logic        regWEN,
    input  logic        Halt,
    input  logic        dMemREN,
    input  logic        dMemWEN,
    input  logic        flush,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        mem_stall,
    output logic [4:0]  wsel,
    output logic [31:0] wdat,
    output logic        wen,
    output logic        halt
);

    typedef enum logic {RUN, WAIT} state_t;

    state_t      state;
    logic        memop;
    logic [4:0]  wsel_p0;
    logic [31:0] wdat_p0;
    logic [4:0]  wsel_p1;
    logic [31:0] wdat_p1;
    logic        wen_p1;
    logic        halt_p1;

    // MEM stage: request qualification and write-back selection
    assign memop     = (dMemREN | dMemWEN) & ~halt_p1 & ~flush;
    assign dmemWEN   = nRST & memop & dMemWEN;
    assign dmemREN   = nRST & memop & dMemREN & ~dMemWEN;
    assign mem_stall = nRST & memop & ~dhit;
    assign dmemaddr  = aluOutport;
    assign dmemstore = rdat2;

    assign wsel_p0 = JType ? 5'd31 : (RegDst ? rd : rt);
    assign wdat_p0 = JType ? pcplus4 : (MemToReg ? dmemload : aluOutport);

    // MEM/WB register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= RUN;
            wsel_p1 <= '0;
            wdat_p1 <= '0;
            wen_p1  <= 1'b0;
            halt_p1 <= 1'b0;
        end else begin
            if (flush) begin
                state <= RUN;
            end else begin
                case (state)
                    RUN:     if (mem_stall)  state <= WAIT;
                    WAIT:    if (!mem_stall) state <= RUN;
                    default: state <= RUN;
                endcase
            end

            // A flushed or still-waiting instruction leaves a bubble behind
            if (flush || mem_stall) begin
                wsel_p1 <= '0;
                wdat_p1 <= '0;
                wen_p1  <= 1'b0;
            end else begin
                wsel_p1 <= wsel_p0;
                wdat_p1 <= wdat_p0;
                wen_p1  <= regWEN & (wsel_p0 != 5'd0) & ~halt_p1;
                if (Halt) halt_p1 <= 1'b1;
            end
        end
    end

    assign wsel = wsel_p1;
    assign wdat = wdat_p1;
    assign wen  = wen_p1;
    assign halt = halt_p1;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU pass-through, load miss, store, flush, JAL, halt, reset.
module tb_mem_wb_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] pcplus4, aluOutport, rdat2, dmemload;
    logic [4:0]  rt, rd;
    logic        MemToReg, JType, RegDst, regWEN, Halt, dMemREN, dMemWEN, flush, dhit;
    logic        dmemREN, dmemWEN, mem_stall, wen, halt;
    logic [31:0] dmemaddr, dmemstore, wdat;
    logic [4:0]  wsel;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    mem_wb_stage dut (
        .CLK(CLK), .nRST(nRST), .pcplus4(pcplus4), .aluOutport(aluOutport), .rdat2(rdat2),
        .rt(rt), .rd(rd), .MemToReg(MemToReg), .JType(JType), .RegDst(RegDst),
        .regWEN(regWEN), .Halt(Halt), .dMemREN(dMemREN), .dMemWEN(dMemWEN), .flush(flush),
        .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_stall(mem_stall),
        .wsel(wsel), .wdat(wdat), .wen(wen), .halt(halt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        pcplus4 = 0; aluOutport = 0; rdat2 = 0; dmemload = 0; rt = 0; rd = 0;
        MemToReg = 0; JType = 0; RegDst = 0; regWEN = 0; Halt = 0;
        dMemREN = 0; dMemWEN = 0; flush = 0; dhit = 0;
    endtask

    task automatic edge_after();
        @(posedge CLK); #1;
    endtask

    initial begin
        clr();
        nRST = 1'b0;
        dMemREN = 1'b1;
        #12;
        check("rst_dmemREN", {31'b0, dmemREN}, 32'd0);
        check("rst_stall", {31'b0, mem_stall}, 32'd0);
        check("rst_wen", {31'b0, wen}, 32'd0);
        check("rst_wsel", {27'b0, wsel}, 32'd0);
        check("rst_wdat", wdat, 32'd0);
        check("rst_halt", {31'b0, halt}, 32'd0);
        @(negedge CLK); nRST = 1'b1; clr();

        // ALU op, dhit high but no request active
        edge_after();
        aluOutport = 32'h1234; rd = 5'd5; RegDst = 1; regWEN = 1; dhit = 1;
        @(negedge CLK);
        check("alu_stall", {31'b0, mem_stall}, 32'd0);
        edge_after();
        check("alu_wsel", {27'b0, wsel}, 32'd5);
        check("alu_wdat", wdat, 32'h1234);
        check("alu_wen", {31'b0, wen}, 32'd1);

        // Load missing for 3 cycles
        clr(); dMemREN = 1; MemToReg = 1; rt = 5'd8; aluOutport = 32'h100; regWEN = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("ld_ren", {31'b0, dmemREN}, 32'd1);
            check("ld_stall", {31'b0, mem_stall}, 32'd1);
            check("ld_addr", dmemaddr, 32'h100);
            edge_after();
            check("ld_bubble_wen", {31'b0, wen}, 32'd0);
        end
        dhit = 1; dmemload = 32'hDEADBEEF;
        @(negedge CLK);
        check("ld_hit_stall", {31'b0, mem_stall}, 32'd0);
        edge_after();
        check("ld_wsel", {27'b0, wsel}, 32'd8);
        check("ld_wdat", wdat, 32'hDEADBEEF);
        check("ld_wen", {31'b0, wen}, 32'd1);

        // Store hit with both strobes set: write wins
        clr(); dMemWEN = 1; dMemREN = 1; rdat2 = 32'hCAFE; dhit = 1;
        @(negedge CLK);
        check("st_wen", {31'b0, dmemWEN}, 32'd1);
        check("st_ren", {31'b0, dmemREN}, 32'd0);
        check("st_data", dmemstore, 32'hCAFE);
        check("st_stall", {31'b0, mem_stall}, 32'd0);
        edge_after();
        check("st_rf_wen", {31'b0, wen}, 32'd0);

        // Flush while a load waits, dhit in the same cycle
        clr(); dMemREN = 1; MemToReg = 1; rt = 5'd9; regWEN = 1;
        edge_after();
        flush = 1; dhit = 1; dmemload = 32'h5555AAAA;
        @(negedge CLK);
        check("fl_ren", {31'b0, dmemREN}, 32'd0);
        check("fl_stall", {31'b0, mem_stall}, 32'd0);
        edge_after();
        check("fl_wen", {31'b0, wen}, 32'd0);
        check("fl_wdat", wdat, 32'd0);
        check("fl_wsel", {27'b0, wsel}, 32'd0);

        // JAL, then a write to $0
        clr(); JType = 1; regWEN = 1; pcplus4 = 32'h44; rt = 5'd3; rd = 5'd7; RegDst = 1;
        edge_after();
        check("jal_wsel", {27'b0, wsel}, 32'd31);
        check("jal_wdat", wdat, 32'h44);
        check("jal_wen", {31'b0, wen}, 32'd1);
        clr(); RegDst = 1; rd = 5'd0; regWEN = 1; aluOutport = 32'h77;
        edge_after();
        check("r0_wen", {31'b0, wen}, 32'd0);

        // Flushed Halt does not set halt
        clr(); Halt = 1; flush = 1;
        edge_after();
        check("fl_halt", {31'b0, halt}, 32'd0);

        // Halt captured, later loads suppressed
        clr(); Halt = 1;
        edge_after();
        check("halt_set", {31'b0, halt}, 32'd1);
        clr(); dMemREN = 1; MemToReg = 1; rt = 5'd8; regWEN = 1;
        @(negedge CLK);
        check("halt_ren", {31'b0, dmemREN}, 32'd0);
        check("halt_stall", {31'b0, mem_stall}, 32'd0);
        edge_after();
        check("halt_rf_wen", {31'b0, wen}, 32'd0);
        check("halt_sticky", {31'b0, halt}, 32'd1);

        // Reset clears halt asynchronously
        #2 nRST = 1'b0; #1;
        check("arst_halt", {31'b0, halt}, 32'd0);
        @(negedge CLK); nRST = 1'b1;

        // Reset in the middle of WAIT
        clr(); dMemREN = 1; MemToReg = 1; rt = 5'd10; regWEN = 1;
        edge_after();
        @(negedge CLK);
        check("w_stall", {31'b0, mem_stall}, 32'd1);
        #2 nRST = 1'b0; #1;
        check("wrst_ren", {31'b0, dmemREN}, 32'd0);
        check("wrst_stall", {31'b0, mem_stall}, 32'd0);
        check("wrst_wen", {31'b0, wen}, 32'd0);
        @(negedge CLK); nRST = 1'b1;
        dhit = 1; dmemload = 32'h0BADF00D;
        edge_after();
        check("post_wsel", {27'b0, wsel}, 32'd10);
        check("post_wdat", wdat, 32'h0BADF00D);
        check("post_wen", {31'b0, wen}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
